// File: rtl/graphics_pkg.sv
// Shared definitions for the graphics command master.
//   - Register addresses of the graphics accelerator slave port
//   - Byte-enable pattern used for every transfer
//   - Controller state encoding
//   - Draw command record carried through the command FIFO
package graphics_pkg;

  localparam logic [2:0] REG_ID       = 3'd0;
  localparam logic [2:0] REG_X        = 3'd1;
  localparam logic [2:0] REG_Y        = 3'd2;
  localparam logic [2:0] REG_START    = 3'd3;
  localparam logic [2:0] REG_DONE     = 3'd4;
  localparam logic [2:0] REG_NEWFRAME = 3'd5;
  localparam logic [2:0] REG_ACK      = 3'd6;

  // The slave only decodes the low 16 bits.
  localparam logic [3:0] AVM_BE = 4'b0011;

  typedef enum logic [3:0] {
    IDLE,
    WAIT_FRAME,
    ACK_SET,
    ACK_CLR,
    FETCH,
    WR_ID,
    WR_X,
    WR_Y,
    WR_START,
    POLL_DONE,
    WR_STOP
  } state_e;

  typedef struct packed {
    logic [2:0] img_id;
    logic [9:0] x;
    logic [9:0] y;
    logic       last;
  } cmd_t;

endpackage

// File: rtl/graphics_cmd_fifo.sv
// Synchronous FIFO of draw commands.
// Ports:
//   Clk, RESET          clock and synchronous active-high reset
//   push, wr_data       write strobe and command; ignored when full
//   pop                 read strobe; ignored when empty
//   rd_data             command at the head (valid while !empty)
//   full, empty         occupancy flags
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module graphics_cmd_fifo
  import graphics_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic Clk,
  input  logic RESET,
  input  logic push,
  input  cmd_t wr_data,
  input  logic pop,
  output cmd_t rd_data,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  cmd_t           mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge Clk) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/graphics_cmd_master.sv
// Avalon-MM master that feeds queued draw commands to the graphics
// accelerator's register slave, one frame per new-frame flag.
// Ports:
//   Clk, RESET                          clock, synchronous active-high reset
//   CMD_VALID/CMD_READY                 command stream handshake
//   CMD_IMG_ID, CMD_X, CMD_Y, CMD_LAST  command fields
//   AVM_*                               Avalon-MM master (registered requests,
//                                       zero-latency read data)
//   BUSY                                controller not idle
//   FRAME_COUNT                         frames fully drawn (wrapping)
//   ERR                                 sticky poll timeout
// Optional build macro GRAPHICS_CMD_MASTER_TIMEOUT_EN bounds each poll
// wait to POLL_TIMEOUT reads; without it polling is unbounded and ERR is 0.
module graphics_cmd_master
  import graphics_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int POLL_TIMEOUT = 4096
) (
  input  logic        Clk,
  input  logic        RESET,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [2:0]  CMD_IMG_ID,
  input  logic [9:0]  CMD_X,
  input  logic [9:0]  CMD_Y,
  input  logic        CMD_LAST,
  output logic        AVM_CS,
  output logic        AVM_READ,
  output logic        AVM_WRITE,
  output logic [2:0]  AVM_ADDR,
  output logic [3:0]  AVM_BYTE_EN,
  output logic [15:0] AVM_WRITEDATA,
  input  logic [15:0] AVM_READDATA,
  input  logic        AVM_WAITREQUEST,
  output logic        BUSY,
  output logic [15:0] FRAME_COUNT,
  output logic        ERR
);

  state_e      state, state_nxt;
  cmd_t        fifo_q, fifo_d, hold, cmd_src;
  logic        fifo_full, fifo_empty, push, pop;
  logic        xfer_done, poll_hit, frame_inc;
  logic        rd_nxt, wr_nxt;
  logic [2:0]  addr_nxt;
  logic [15:0] data_nxt;
  logic        poll_to, drop;

  assign CMD_READY = !fifo_full && !RESET;
  assign push      = CMD_VALID && CMD_READY;
  assign fifo_d    = '{img_id: CMD_IMG_ID, x: CMD_X, y: CMD_Y, last: CMD_LAST};
  assign BUSY      = (state != IDLE);
  assign xfer_done = (AVM_READ || AVM_WRITE) && !AVM_WAITREQUEST;
  assign poll_hit  = AVM_READDATA[0];

  graphics_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .Clk     (Clk),
    .RESET   (RESET),
    .push    (push),
    .wr_data (fifo_d),
    .pop     (pop),
    .rd_data (fifo_q),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // The command popped in FETCH is written as ID in the very next cycle,
  // so the ID request is built from the FIFO head before it lands in hold.
  assign cmd_src = (state == FETCH) ? fifo_q : hold;

  always_comb begin
    state_nxt = state;
    frame_inc = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE:       if (!fifo_empty) state_nxt = WAIT_FRAME;
      WAIT_FRAME: if (xfer_done && poll_hit) state_nxt = ACK_SET;
      ACK_SET:    if (xfer_done) state_nxt = ACK_CLR;
      ACK_CLR:    if (xfer_done) state_nxt = FETCH;
      FETCH: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = WR_ID;
        end
      end
      WR_ID:      if (xfer_done) state_nxt = WR_X;
      WR_X:       if (xfer_done) state_nxt = WR_Y;
      WR_Y:       if (xfer_done) state_nxt = WR_START;
      WR_START:   if (xfer_done) state_nxt = POLL_DONE;
      POLL_DONE:  if (xfer_done && (poll_hit || poll_to)) state_nxt = WR_STOP;
      WR_STOP: begin
        if (xfer_done) begin
          if (hold.last) begin
            frame_inc = !drop;
            state_nxt = fifo_empty ? IDLE : WAIT_FRAME;
          end else begin
            state_nxt = FETCH;
          end
        end
      end
      default:    state_nxt = IDLE;
    endcase
  end

  // Requests are a pure function of the state being entered; a stalled
  // transfer re-enters its own state and so re-presents the same request.
  always_comb begin
    rd_nxt   = 1'b0;
    wr_nxt   = 1'b0;
    addr_nxt = REG_ID;
    data_nxt = '0;
    case (state_nxt)
      WAIT_FRAME: begin rd_nxt = 1'b1; addr_nxt = REG_NEWFRAME; end
      ACK_SET:    begin wr_nxt = 1'b1; addr_nxt = REG_ACK;   data_nxt = 16'h0001; end
      ACK_CLR:    begin wr_nxt = 1'b1; addr_nxt = REG_ACK;   data_nxt = 16'h0000; end
      WR_ID:      begin wr_nxt = 1'b1; addr_nxt = REG_ID;    data_nxt = {13'b0, cmd_src.img_id}; end
      WR_X:       begin wr_nxt = 1'b1; addr_nxt = REG_X;     data_nxt = {6'b0, cmd_src.x}; end
      WR_Y:       begin wr_nxt = 1'b1; addr_nxt = REG_Y;     data_nxt = {6'b0, cmd_src.y}; end
      WR_START:   begin wr_nxt = 1'b1; addr_nxt = REG_START; data_nxt = 16'h0001; end
      POLL_DONE:  begin rd_nxt = 1'b1; addr_nxt = REG_DONE; end
      WR_STOP:    begin wr_nxt = 1'b1; addr_nxt = REG_START; data_nxt = 16'h0000; end
      default:    ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (RESET) begin
      state         <= IDLE;
      AVM_CS        <= 1'b0;
      AVM_READ      <= 1'b0;
      AVM_WRITE     <= 1'b0;
      AVM_ADDR      <= '0;
      AVM_BYTE_EN   <= '0;
      AVM_WRITEDATA <= '0;
      FRAME_COUNT   <= '0;
    end else begin
      state         <= state_nxt;
      AVM_CS        <= rd_nxt || wr_nxt;
      AVM_READ      <= rd_nxt;
      AVM_WRITE     <= wr_nxt;
      AVM_ADDR      <= addr_nxt;
      AVM_BYTE_EN   <= (rd_nxt || wr_nxt) ? AVM_BE : 4'b0000;
      AVM_WRITEDATA <= data_nxt;
      if (frame_inc) FRAME_COUNT <= FRAME_COUNT + 16'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (pop) hold <= fifo_q;
  end

`ifdef GRAPHICS_CMD_MASTER_TIMEOUT_EN
  logic [15:0] poll_cnt;
  logic        poll_rd_done;
  logic        poll_enter;
  logic        unused_rd;

  assign unused_rd    = ^AVM_READDATA[15:1];
  assign poll_rd_done = xfer_done && AVM_READ;
  assign poll_enter   = (state_nxt == WAIT_FRAME && state != WAIT_FRAME) ||
                        (state_nxt == POLL_DONE  && state != POLL_DONE);
  assign poll_to      = poll_rd_done && !poll_hit &&
                        (poll_cnt + 16'd1 == 16'(POLL_TIMEOUT));

  // A timeout in WAIT_FRAME simply restarts the count; in POLL_DONE the
  // command is abandoned after START is cleared and never counts as drawn.
  always_ff @(posedge Clk) begin
    if (RESET) begin
      poll_cnt <= '0;
      ERR      <= 1'b0;
      drop     <= 1'b0;
    end else begin
      if (poll_enter || poll_to) poll_cnt <= '0;
      else if (poll_rd_done)     poll_cnt <= poll_cnt + 16'd1;
      if (poll_to) ERR <= 1'b1;
      if (poll_to && state == POLL_DONE) drop <= 1'b1;
      else if (pop)                      drop <= 1'b0;
    end
  end
`else
  logic unused_cfg;

  // Only bit0 of a poll is meaningful; the timeout limit has no use here.
  assign unused_cfg = ^{AVM_READDATA[15:1], 32'(POLL_TIMEOUT)};
  assign poll_to    = 1'b0;
  assign drop       = 1'b0;
  assign ERR        = 1'b0;
`endif

endmodule

// File: tb/tb_graphics_cmd_master.sv
module tb_graphics_cmd_master;

`ifdef GRAPHICS_CMD_MASTER_TIMEOUT_EN
  localparam int TB_POLL_TIMEOUT = 4;
`else
  localparam int TB_POLL_TIMEOUT = 4096;
`endif

  logic        Clk = 1'b0;
  logic        RESET = 1'b1;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic [2:0]  CMD_IMG_ID = '0;
  logic [9:0]  CMD_X = '0;
  logic [9:0]  CMD_Y = '0;
  logic        CMD_LAST = 1'b0;
  logic        AVM_CS, AVM_READ, AVM_WRITE;
  logic [2:0]  AVM_ADDR;
  logic [3:0]  AVM_BYTE_EN;
  logic [15:0] AVM_WRITEDATA;
  logic [15:0] AVM_READDATA = '0;
  logic        AVM_WAITREQUEST = 1'b0;
  logic        BUSY;
  logic [15:0] FRAME_COUNT;
  logic        ERR;

  graphics_cmd_master #(.FIFO_DEPTH(8), .POLL_TIMEOUT(TB_POLL_TIMEOUT)) dut (
    .Clk(Clk), .RESET(RESET), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_IMG_ID(CMD_IMG_ID), .CMD_X(CMD_X), .CMD_Y(CMD_Y), .CMD_LAST(CMD_LAST),
    .AVM_CS(AVM_CS), .AVM_READ(AVM_READ), .AVM_WRITE(AVM_WRITE),
    .AVM_ADDR(AVM_ADDR), .AVM_BYTE_EN(AVM_BYTE_EN),
    .AVM_WRITEDATA(AVM_WRITEDATA), .AVM_READDATA(AVM_READDATA),
    .AVM_WAITREQUEST(AVM_WAITREQUEST), .BUSY(BUSY),
    .FRAME_COUNT(FRAME_COUNT), .ERR(ERR)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model: expected write stream ----------------
  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
    bit          frame_end;
  } exp_t;

  exp_t exp_q[$];
  bit   frame_open = 0;
  int   exp_frames = 0;

  // Each accepted command becomes five register writes; the first command
  // of a frame is preceded by the ACK set/clear pair.
  function automatic void model_push(logic [2:0] id, logic [9:0] x, logic [9:0] y, logic last);
    if (!frame_open) begin
      exp_q.push_back('{3'd6, 16'd1, 1'b0});
      exp_q.push_back('{3'd6, 16'd0, 1'b0});
      frame_open = 1;
    end
    exp_q.push_back('{3'd0, 16'(id), 1'b0});
    exp_q.push_back('{3'd1, 16'(x), 1'b0});
    exp_q.push_back('{3'd2, 16'(y), 1'b0});
    exp_q.push_back('{3'd3, 16'd1, 1'b0});
    exp_q.push_back('{3'd3, 16'd0, last});
    if (last) frame_open = 0;
  endfunction

  // ---------------- slave model ----------------
  bit          nf_hold = 0, done_stuck = 0, rand_tgt = 0, ws_rand = 0;
  int          nf_cnt = 0, done_cnt = 0, nf_target = 2, done_target = 1;
  int          ws_x_left = 0;
  logic [9:0]  ws_x_data = '0;

  initial begin
    logic [31:0] rnd;
    logic        wr, b;
    forever begin
      @(posedge Clk);
      #1;
      wr = 1'b0;
      if (ws_x_left > 0 && AVM_WRITE && AVM_ADDR == 3'd1) begin
        check("x_stall_data", AVM_WRITEDATA, {6'b0, ws_x_data});
        wr = 1'b1;
        ws_x_left--;
      end else if (ws_rand && (AVM_READ || AVM_WRITE) && $urandom_range(0, 3) == 0) begin
        wr = 1'b1;
      end
      AVM_WAITREQUEST = wr;
      rnd = $urandom;
      b   = 1'b0;
      if (AVM_READ && !wr) begin
        if (AVM_ADDR == 3'd5) begin
          b = !nf_hold && (nf_cnt >= nf_target);
          nf_cnt++;
          if (b) begin
            nf_cnt = 0;
            if (rand_tgt) nf_target = $urandom_range(0, 3);
          end
        end else if (AVM_ADDR == 3'd4) begin
          b = !done_stuck && (done_cnt >= done_target);
          done_cnt++;
          if (b) begin
            done_cnt = 0;
            if (rand_tgt) done_target = $urandom_range(0, 3);
          end
        end
      end
      AVM_READDATA = {rnd[15:1], b};
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit   hit_nf = 0, hit_done = 0, chk_fc = 0, to_mode = 0;
  int   done_reads = 0, nf_total = 0, done_total = 0, ack0_cnt = 0;

  always @(negedge Clk) begin
    logic [2:0] ea;
    exp_t       e;
    if (RESET) begin
      hit_nf = 0; hit_done = 0; chk_fc = 0; done_reads = 0;
    end else begin
      if (chk_fc) begin
        check("frame_count", FRAME_COUNT, exp_frames);
        chk_fc = 0;
      end
      if (AVM_READ || AVM_WRITE) begin
        check("cs_with_req", AVM_CS, 1);
        check("byte_en", AVM_BYTE_EN, 4'b0011);
        check("rd_wr_excl", AVM_READ && AVM_WRITE, 0);
        if (!AVM_WAITREQUEST) begin
          if (AVM_READ) begin
            ea = 3'd7;
            if (exp_q.size() > 0) begin
              if (exp_q[0].addr == 3'd6 && exp_q[0].data == 16'd1) ea = 3'd5;
              else if (exp_q[0].addr == 3'd3 && exp_q[0].data == 16'd0) ea = 3'd4;
            end
            check("read_addr", AVM_ADDR, ea);
            if (ea == 3'd5) begin
              check("read_after_newframe", hit_nf, 0);
              nf_total++;
              if (AVM_READDATA[0]) hit_nf = 1;
            end else if (ea == 3'd4) begin
              check("read_after_done", hit_done, 0);
              done_total++;
              done_reads++;
              if (AVM_READDATA[0]) hit_done = 1;
            end
          end else if (exp_q.size() == 0) begin
            check("write_unexpected", AVM_ADDR, 3'd7);
          end else begin
            e = exp_q.pop_front();
            check("write_addr", AVM_ADDR, e.addr);
            check("write_data", AVM_WRITEDATA, e.data);
            if (e.addr == 3'd6 && e.data == 16'd1) begin
              check("ack_after_newframe", hit_nf, 1);
              hit_nf = 0;
            end
            if (e.addr == 3'd6 && e.data == 16'd0) ack0_cnt++;
            if (e.addr == 3'd3 && e.data == 16'd0) begin
              if (to_mode) check("timeout_done_reads", done_reads, TB_POLL_TIMEOUT);
              else         check("stop_after_done", hit_done, 1);
              hit_done = 0;
              done_reads = 0;
              if (e.frame_end && !to_mode) begin
                exp_frames++;
                chk_fc = 1;
              end
            end
          end
        end
      end else begin
        check("idle_cs", {AVM_CS, AVM_BYTE_EN}, 0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int acc_ack0 = 0;

  task automatic send(input logic [2:0] id, input logic [9:0] x, input logic [9:0] y,
                      input logic last);
    int n = 0;
    @(negedge Clk);
    CMD_VALID = 1'b1; CMD_IMG_ID = id; CMD_X = x; CMD_Y = y; CMD_LAST = last;
    while (!CMD_READY && n < 400) begin
      @(negedge Clk);
      n++;
    end
    check("cmd_accept", CMD_READY, 1);
    if (CMD_READY) begin
      @(posedge Clk);
      model_push(id, x, y, last);
      acc_ack0 = ack0_cnt;
      #1;
    end
    CMD_VALID = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input string name);
    int n = 0;
    while (!(exp_q.size() == 0 && !BUSY) && n < bound) begin
      @(negedge Clk);
      n++;
    end
    check(name, (exp_q.size() == 0 && !BUSY), 1);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int n, ack0_before;
    logic [2:0] rid;
    logic [9:0] rx, ry;

    // reset behaviour
    @(posedge Clk); #1;
    check("ready_in_reset", CMD_READY, 0);
    check("avm_in_reset", {AVM_CS, AVM_READ, AVM_WRITE, AVM_BYTE_EN}, 0);
    @(posedge Clk); #1;
    RESET = 1'b0;
    #1;
    check("ready_after_reset", CMD_READY, 1);
    check("busy_reset", BUSY, 0);
    check("fc_reset", FRAME_COUNT, 0);
    check("err_reset", ERR, 0);
    check("avm_reset", {AVM_CS, AVM_READ, AVM_WRITE, AVM_ADDR, AVM_BYTE_EN, AVM_WRITEDATA}, 0);

    // single-command frame, scripted polls
    send(3'd3, 10'd100, 10'd50, 1'b1);
    wait_idle(500, "t1_idle");
    check("t1_fc", FRAME_COUNT, 1);
    check("t1_busy", BUSY, 0);
    check("t1_nf_reads", nf_total, 3);
    check("t1_done_reads", done_total, 2);

    // two-command frame
    ack0_before = ack0_cnt;
    send(3'd1, 10'd10, 10'd20, 1'b0);
    send(3'd2, 10'd30, 10'd40, 1'b1);
    wait_idle(500, "t2_idle");
    check("t2_fc", FRAME_COUNT, 2);
    check("t2_one_ack", ack0_cnt - ack0_before, 1);

    // FIFO fill with no new frame
    nf_hold = 1;
    for (int i = 0; i < 8; i++) send(3'(i), 10'(i * 3), 10'(i * 7), i == 7);
    @(negedge Clk);
    check("full_not_ready", CMD_READY, 0);
    ack0_before = ack0_cnt;
    fork
      send(3'd5, 10'd555, 10'd333, 1'b1);
      begin
        repeat (5) @(negedge Clk);
        check("full_held", CMD_READY, 0);
        nf_hold = 0;
      end
    join
    check("ninth_after_pop", acc_ack0 > ack0_before, 1);
    wait_idle(2000, "t3_idle");

    // waitrequest on the X write
    ws_x_data = 10'd777;
    ws_x_left = 3;
    send(3'd4, 10'd777, 10'd88, 1'b1);
    wait_idle(500, "t4_idle");
    check("x_stall_cycles", ws_x_left, 0);

    // reset while polling DONE
    done_stuck = 1;
    send(3'd6, 10'd1, 10'd2, 1'b1);
    n = 0;
    while (!(AVM_READ && AVM_ADDR == 3'd4) && n < 300) begin
      @(posedge Clk); #1;
      n++;
    end
    check("reached_poll_done", AVM_READ && AVM_ADDR == 3'd4, 1);
    RESET = 1'b1;
    @(posedge Clk); #1;
    check("rst_avm", {AVM_CS, AVM_READ, AVM_WRITE, AVM_ADDR, AVM_BYTE_EN, AVM_WRITEDATA}, 0);
    check("rst_busy", BUSY, 0);
    check("rst_fc", FRAME_COUNT, 0);
    check("rst_ready", CMD_READY, 0);
    exp_q.delete();
    frame_open = 0;
    exp_frames = 0;
    done_stuck = 0;
    RESET = 1'b0;
    repeat (5) @(negedge Clk);
    check("rst_fifo_empty", BUSY, 0);
    check("rst_ready_after", CMD_READY, 1);

    // randomized traffic
    rand_tgt = 1;
    ws_rand  = 1;
    for (int i = 0; i < 40; i++) begin
      rid = 3'($urandom);
      rx  = 10'($urandom);
      ry  = 10'($urandom);
      send(rid, rx, ry, (i == 39) || ($urandom_range(0, 2) == 0));
      repeat ($urandom_range(0, 3)) @(negedge Clk);
    end
    wait_idle(20000, "rand_idle");
    ws_rand = 0;

`ifdef GRAPHICS_CMD_MASTER_TIMEOUT_EN
    to_mode    = 1;
    done_stuck = 1;
    send(3'd7, 10'd300, 10'd400, 1'b1);
    wait_idle(2000, "timeout_idle");
    check("timeout_err", ERR, 1);
    check("timeout_fc", FRAME_COUNT, exp_frames);
    to_mode    = 0;
    done_stuck = 0;
`else
    check("err_zero", ERR, 0);
`endif

    check("final_fc", FRAME_COUNT, exp_frames);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
